// File: rtl/riscv_mem_pkg.sv
// Shared RV32I load/store definitions.
// Used by the data memory responder and the core's decode logic.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the memory stage
// and the data memory responder.
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads and stores:
// enables, store shift, load extension and error flags.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        write,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] sh;

  assign sh       = rword >> {lane, 3'b000};
  assign wdata_sh = wdata << {lane, 3'b000};

  always_comb begin
    be       = 4'b0000;
    rdata    = 32'h0;
    misalign = 1'b0;
    illegal  = 1'b0;
    unique case (funct3)
      F3_B: begin
        be    = 4'b0001 << lane;
        rdata = {{24{sh[7]}}, sh[7:0]};
      end
      F3_BU: begin
        illegal = write;
        rdata   = {24'h0, sh[7:0]};
      end
      F3_H: begin
        misalign = lane[0];
        be       = 4'b0011 << lane;
        rdata    = {{16{sh[15]}}, sh[15:0]};
      end
      F3_HU: begin
        illegal  = write;
        misalign = lane[0];
        rdata    = {16'h0, sh[15:0]};
      end
      F3_W: begin
        misalign = |lane;
        be       = 4'b1111;
        rdata    = rword;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: one outstanding load/store,
// fixed wait states, byte-addressed word RAM.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        c_write;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [2:0]  c_f3;

  logic        accept;
  logic        do_access;
  logic        a_write;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [2:0]  a_f3;
  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic [31:0] ld_data;
  logic        misalign;
  logic        illegal;
  logic        err;
  logic [DATA_WIDTH-1:0] rword;
  logic [ADDR_WIDTH-3:0] idx;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  assign bus.req_ready = (state == ST_IDLE) && !reset;
  assign bus.rsp_valid = (state == ST_RESP);
  assign accept = bus.req_ready && bus.req_valid;

  // zero wait states access straight off the request inputs
  assign a_write = (state == ST_IDLE) ? bus.req_write  : c_write;
  assign a_addr  = (state == ST_IDLE) ? bus.req_addr   : c_addr;
  assign a_wdata = (state == ST_IDLE) ? bus.req_wdata  : c_wdata;
  assign a_f3    = (state == ST_IDLE) ? bus.req_funct3 : c_f3;

  assign do_access = (accept && WS == 4'd0) ||
                     (state == ST_WAIT && cnt == 4'd1);

  assign idx   = a_addr[ADDR_WIDTH-1:2];
  assign rword = mem[idx];
  assign err   = misalign || illegal || (|a_addr[31:ADDR_WIDTH]);

  mem_lane_align u_align (
    .funct3   (a_f3),
    .write    (a_write),
    .lane     (a_addr[1:0]),
    .wdata    (a_wdata),
    .rword    (rword),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (ld_data),
    .misalign (misalign),
    .illegal  (illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= 4'd0;
      c_write       <= 1'b0;
      c_addr        <= 32'h0;
      c_wdata       <= 32'h0;
      c_f3          <= 3'b000;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_error <= 1'b0;
    end else begin
      if (do_access) begin
        bus.rsp_rdata <= (err || a_write) ? 32'h0 : ld_data;
        bus.rsp_error <= err;
      end
      unique case (state)
        ST_IDLE: if (accept) begin
          c_write <= bus.req_write;
          c_addr  <= bus.req_addr;
          c_wdata <= bus.req_wdata;
          c_f3    <= bus.req_funct3;
          if (WS == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt   <= WS;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: if (cnt == 4'd1) begin
          cnt   <= 4'd0;
          state <= ST_RESP;
        end else begin
          cnt <= cnt - 4'd1;
        end
        ST_RESP: if (bus.rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_access && a_write && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: WAIT_STATES=0 and 2 instances
// against a byte-array reference model.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus2 ();

  data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(2))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic        rv [2];
  logic        rw [2];
  logic [31:0] ra [2];
  logic [31:0] wd [2];
  logic [2:0]  f3 [2];
  logic        rr [2];
  logic        o_rdy [2];
  logic        o_v [2];
  logic [31:0] o_d [2];
  logic        o_e [2];

  assign bus0.req_valid  = rv[0];
  assign bus0.req_write  = rw[0];
  assign bus0.req_addr   = ra[0];
  assign bus0.req_wdata  = wd[0];
  assign bus0.req_funct3 = f3[0];
  assign bus0.rsp_ready  = rr[0];
  assign bus2.req_valid  = rv[1];
  assign bus2.req_write  = rw[1];
  assign bus2.req_addr   = ra[1];
  assign bus2.req_wdata  = wd[1];
  assign bus2.req_funct3 = f3[1];
  assign bus2.rsp_ready  = rr[1];
  assign o_rdy[0] = bus0.req_ready;
  assign o_v[0]   = bus0.rsp_valid;
  assign o_d[0]   = bus0.rsp_rdata;
  assign o_e[0]   = bus0.rsp_error;
  assign o_rdy[1] = bus2.req_ready;
  assign o_v[1]   = bus2.rsp_valid;
  assign o_d[1]   = bus2.rsp_rdata;
  assign o_e[1]   = bus2.rsp_error;

  int total = 0;
  int bad = 0;
  logic [7:0] mref [2][1024];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: legality by access size, little-endian byte storage.
  function automatic void model(input int d, input bit w,
                                input logic [31:0] a, input logic [31:0] wv,
                                input logic [2:0] f, output bit e,
                                output logic [31:0] r);
    int sz;
    bit sgn;
    bit ok;
    ok = 1; sz = 1; sgn = 0; r = 32'h0;
    case (f)
      3'd0: begin sz = 1; sgn = 1; end
      3'd1: begin sz = 2; sgn = 1; end
      3'd2: sz = 4;
      3'd4: begin sz = 1; if (w) ok = 0; end
      3'd5: begin sz = 2; if (w) ok = 0; end
      default: ok = 0;
    endcase
    if (int'(a[1:0]) % sz != 0) ok = 0;
    if (a >= 32'd1024) ok = 0;
    e = !ok;
    if (!ok) return;
    if (w) begin
      for (int i = 0; i < sz; i++) mref[d][int'(a[9:0]) + i] = wv[8*i +: 8];
    end else begin
      for (int i = 0; i < sz; i++) r[8*i +: 8] = mref[d][int'(a[9:0]) + i];
      if (sgn && r[8*sz-1]) for (int i = 8*sz; i < 32; i++) r[i] = 1'b1;
    end
  endfunction

  task automatic op(input int d, input bit w, input logic [31:0] a,
                    input logic [31:0] wv, input logic [2:0] f,
                    input bit bp);
    bit ee;
    logic [31:0] er;
    int lat;
    int ws;
    ws = (d == 1) ? 2 : 0;
    model(d, w, a, wv, f, ee, er);
    @(negedge clk);
    check("req_ready_idle", 32'(o_rdy[d]), 32'd1);
    rv[d] = 1; rw[d] = w; ra[d] = a; wd[d] = wv; f3[d] = f; rr[d] = !bp;
    @(posedge clk); #1;
    rv[d] = 0; rw[d] = 1'($urandom); ra[d] = $urandom;
    wd[d] = $urandom; f3[d] = 3'($urandom);
    lat = 1;
    while (!o_v[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(ws + 1));
    check("rdata", o_d[d], er);
    check("error", 32'(o_e[d]), 32'(ee));
    if (bp) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        rv[d] = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check("bp_valid", 32'(o_v[d]), 32'd1);
        check("bp_rdata", o_d[d], er);
        check("bp_error", 32'(o_e[d]), 32'(ee));
        check("bp_ready", 32'(o_rdy[d]), 32'd0);
      end
      @(negedge clk);
      rv[d] = 0; rr[d] = 1;
    end
    @(posedge clk); #1;
    check("rsp_done", 32'(o_v[d]), 32'd0);
  endtask

  task automatic basic(input int d);
    op(d, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0);
    op(d, 0, 32'h10, 32'h0, 3'b010, 0);
    op(d, 1, 32'h13, 32'h000000A5, 3'b000, 0);
    op(d, 0, 32'h13, 32'h0, 3'b000, 0);
    op(d, 0, 32'h13, 32'h0, 3'b100, 0);
    op(d, 0, 32'h10, 32'h0, 3'b010, 0);
  endtask

  initial begin
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 0; rw[d] = 0; ra[d] = 0; wd[d] = 0; f3[d] = 0; rr[d] = 1;
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", 32'(o_v[d]), 32'd0);
      check("rst_rdata", o_d[d], 32'h0);
      check("rst_error", 32'(o_e[d]), 32'd0);
      check("rst_ready", 32'(o_rdy[d]), 32'd0);
    end
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    check("ready_after_rst", 32'(o_rdy[1]), 32'd1);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i += 4) op(d, 1, 32'(i), $urandom, 3'b010, 0);

    basic(1);
    basic(0);

    op(1, 1, 32'h12, 32'h00008001, 3'b001, 0);
    op(1, 0, 32'h12, 32'h0, 3'b001, 0);
    op(1, 0, 32'h12, 32'h0, 3'b101, 0);
    op(1, 0, 32'h11, 32'h0, 3'b001, 0);
    op(1, 1, 32'h11, 32'h11111111, 3'b010, 0);
    op(1, 0, 32'h10, 32'h0, 3'b010, 0);

    op(1, 0, 32'h10, 32'h0, 3'b010, 1);

    op(1, 0, 32'h400, 32'h0, 3'b010, 0);
    op(1, 0, 32'h14, 32'h0, 3'b011, 0);
    op(1, 1, 32'h14, 32'h000000FF, 3'b100, 0);
    op(1, 0, 32'h14, 32'h0, 3'b010, 0);

    op(1, 1, 32'h20, 32'hCAFEF00D, 3'b010, 0);
    @(negedge clk);
    rv[1] = 1; rw[1] = 1; ra[1] = 32'h20; wd[1] = 32'h12345678; f3[1] = 3'b010;
    @(posedge clk); #1;
    rv[1] = 0;
    reset = 1;
    #1;
    check("mid_rst_valid", 32'(o_v[1]), 32'd0);
    check("mid_rst_ready", 32'(o_rdy[1]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    check("mid_rst_release", 32'(o_rdy[1]), 32'd1);
    op(1, 0, 32'h20, 32'h0, 3'b010, 0);

    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = 32'h400 + 32'($urandom_range(0, 255));
      op(i % 2, 1'($urandom_range(0, 1)), a, $urandom,
         3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
